// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: stalls, flushes, EX forwarding,
// mult/div freeze sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LATENCY  = 32,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic [4:0]             ex_rs,
  input  logic [4:0]             ex_rt,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic                   ex_branch_taken,
  input  logic                   ex_md_start,
  input  logic [4:0]             mem_rd,
  input  logic [4:0]             wb_rd,
  input  logic                   mem_regwrite,
  input  logic                   wb_regwrite,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {StRun, StMdWait} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   load_use;

  // EX/MEM wins over MEM/WB; $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_rd,
                                         input logic m_we, input logic [4:0] w_rd,
                                         input logic w_we);
    if (m_we && m_rd != 5'd0 && m_rd == src)      return 2'b01;
    else if (w_we && w_rd != 5'd0 && w_rd == src) return 2'b10;
    else                                          return 2'b00;
  endfunction

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    fwd_a       = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    fwd_b       = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

    unique case (state_q)
      StRun: begin
        if (ex_md_start) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          md_busy     = 1'b1;
          state_d     = StMdWait;
          cnt_d       = CNT_W'(MD_LATENCY - 1);
        end else if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      StMdWait: begin
        if (cnt_q != '0) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          md_busy     = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
        end else begin
          md_done = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // Reset forces a quiescent, fully flushed pipeline without waiting for a clock.
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      md_busy     = 1'b0;
      md_done     = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

  // ex_regwrite is part of the EX interface but not needed for these decisions.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_LATENCY=4, 4-bit stall counter).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_branch_taken, ex_md_start;
  logic       mem_regwrite, wb_regwrite;
  logic       pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_busy, md_done;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt;
  logic [7:0] ctrl;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pipe_hazard_ctrl #(
    .MD_LATENCY (4),
    .CNT_W      (6),
    .STALL_CNT_W(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start    (ex_md_start),
    .mem_rd         (mem_rd),
    .wb_rd          (wb_rd),
    .mem_regwrite   (mem_regwrite),
    .wb_regwrite    (wb_regwrite),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_busy, md_done}
  assign ctrl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_busy, md_done};

  localparam logic [7:0] CtlReset   = 8'h1C;
  localparam logic [7:0] CtlRun     = 8'hE0;
  localparam logic [7:0] CtlLu      = 8'h28;
  localparam logic [7:0] CtlBranch  = 8'hF8;
  localparam logic [7:0] CtlFreeze  = 8'h06;
  localparam logic [7:0] CtlRelease = 8'hE1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    ex_branch_taken = 0; ex_md_start = 0;
    mem_rd = 0; wb_rd = 0; mem_regwrite = 0; wb_regwrite = 0;
  endtask

  task automatic set_fwd(input logic [4:0] mrd, input logic mwe, input logic [4:0] wrd,
                         input logic wwe, input logic [4:0] rs, input logic [4:0] rt);
    mem_rd = mrd; mem_regwrite = mwe; wb_rd = wrd; wb_regwrite = wwe; ex_rs = rs; ex_rt = rt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    set_fwd(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 5'd5);
    #3;
    check("reset_ctrl", ctrl, CtlReset);
    check("reset_fwd", {fwd_a, fwd_b}, 4'b0000);
    check("reset_stall", stall_cnt, 0);
    #9 rst_n = 1'b1;  // t=12, away from any posedge
    clear_inputs();
    #1 check("run_idle", ctrl, CtlRun);

    set_fwd(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    #1 check("fwd_mem_wins", {fwd_a, fwd_b}, 4'b0101);
    mem_regwrite = 1'b0;
    #1 check("fwd_wb", {fwd_a, fwd_b}, 4'b1010);
    set_fwd(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    #1 check("fwd_zero", {fwd_a, fwd_b}, 4'b0000);
    set_fwd(5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 5'd6);
    #1 check("fwd_split", {fwd_a, fwd_b}, 4'b0110);
    clear_inputs();

    // Load-use via rs
    @(negedge clk);
    ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    #1 check("lu_rs", ctrl, CtlLu);
    check("lu_stall_before", stall_cnt, 0);
    @(negedge clk);
    check("lu_stall_after", stall_cnt, 1);
    id_use_rs = 0;
    #1 check("lu_no_use", ctrl, CtlRun);
    @(negedge clk);
    id_use_rs = 1; ex_rd = 0; id_rs = 0;
    #1 check("lu_rd_zero", ctrl, CtlRun);
    @(negedge clk);
    check("lu_stall_hold", stall_cnt, 1);
    id_use_rs = 0; ex_rd = 8; id_rt = 8; id_use_rt = 1;
    #1 check("lu_rt", ctrl, CtlLu);
    @(negedge clk);
    check("lu_rt_stall", stall_cnt, 2);
    ex_branch_taken = 1;
    #1 check("branch_over_lu", ctrl, CtlBranch);
    @(negedge clk);
    check("branch_stall", stall_cnt, 2);
    clear_inputs();

    // Mult/div, then a back-to-back second op with start still held at release
    @(negedge clk);
    ex_md_start = 1;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c == 5 || c == 10) check("md_release", ctrl, CtlRelease);
      else                   check("md_freeze", ctrl, CtlFreeze);
      if (c == 5) check("md_stall_first", stall_cnt, 6);
      @(negedge clk);
      if (c == 1) begin
        ex_branch_taken = 1; ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
      end
      if (c == 4) begin
        ex_branch_taken = 0; ex_memread = 0; ex_rd = 0; id_rs = 0; id_use_rs = 0;
      end
      if (c == 6) ex_md_start = 0;
    end
    #1 check("md_after", ctrl, CtlRun);
    check("md_stall_total", stall_cnt, 10);
    clear_inputs();

    // Reset in the middle of a freeze
    @(negedge clk);
    ex_md_start = 1;
    @(negedge clk);
    ex_md_start = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_ctrl", ctrl, CtlReset);
    check("midreset_stall", stall_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 check("post_reset_run", ctrl, CtlRun);
      @(negedge clk);
    end
    check("post_reset_stall", stall_cnt, 0);

    // Saturation of the 4-bit stall counter
    ex_memread = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("sat_stall", stall_cnt, (i > 15) ? 15 : i);
    end
    clear_inputs();
    @(negedge clk);
    check("sat_final", stall_cnt, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
